fir_axil_param: RTL and testbench

FIR_AXIL_PARAM -- requirements
Module: fir_axil_param

---
 rtl/fir_axil_param.sv | 268 ++++++++++++++++++++++++++
 tb/tb_fir_axil_param.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axil_param.sv
// AXI4-Lite slave around a sequential FIR engine doing one multiply-accumulate per clock.
// Optional feature: define FIR_SATURATE_EN to clamp out-of-range results and flag overflow.
module fir_axil_param #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned NUM_TAPS           = 16,
    parameter int unsigned SAMPLE_W           = 16,
    parameter int unsigned COEF_W             = 16
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            irq
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned WORD_W   = AW - 2;
    localparam int unsigned TW       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned PW       = SAMPLE_W + COEF_W;
    localparam int unsigned ACC_W    = PW + 4;
    localparam int unsigned RW       = ACC_W - (COEF_W - 1);
    localparam int unsigned CoefBase = 16;

    localparam logic [WORD_W-1:0] WordCtrl   = WORD_W'(0);
    localparam logic [WORD_W-1:0] WordStatus = WORD_W'(1);
    localparam logic [WORD_W-1:0] WordDin    = WORD_W'(2);
    localparam logic [WORD_W-1:0] WordDout   = WORD_W'(3);

    localparam logic signed [RW-1:0] SatMax = {{(RW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [RW-1:0] SatMin = {{(RW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    // Bus handshake state
    logic          awready_q, bvalid_q, arready_q, rvalid_q, rd_dout_q;
    logic [DW-1:0] rdata_q;
    logic          wr_fire, rd_fire;

    // Engine and register state
    state_e                     state_q, state_d;
    logic [TW-1:0]              tap_q, tap_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] hist_q [NUM_TAPS];
    logic signed [SAMPLE_W-1:0] hist_d [NUM_TAPS];
    logic [COEF_W-1:0]          coef_q [NUM_TAPS];
    logic [COEF_W-1:0]          coef_d [NUM_TAPS];
    logic                       enable_q, enable_d;
    logic signed [SAMPLE_W-1:0] dout_q, dout_d;
    logic                       out_valid_q, out_valid_d;
    logic                       overflow_q, overflow_d;
    logic                       drop_q, drop_d;

    logic                       busy, clr_hist, din_wr;
    logic [WORD_W-1:0]          wr_word, rd_word;
    logic                       wr_coef, rd_coef;
    logic [TW-1:0]              wr_idx, rd_idx;
    logic [DW-1:0]              strb_mask, rd_data;
    logic signed [PW-1:0]       mul_x, mul_c, prod;
    logic signed [RW-1:0]       acc_sh;
    logic [SAMPLE_W-1:0]        result;
    logic                       result_ovf;
    logic                       unused_bits;

    assign wr_fire = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_fire = arready_q & s00_axi_arvalid;
    assign busy    = (state_q != StIdle);

    assign wr_word = s00_axi_awaddr[AW-1:2];
    assign rd_word = s00_axi_araddr[AW-1:2];

    always_comb begin
        wr_coef = (32'(wr_word) >= CoefBase) && (32'(wr_word) < CoefBase + NUM_TAPS);
        rd_coef = (32'(rd_word) >= CoefBase) && (32'(rd_word) < CoefBase + NUM_TAPS);
        wr_idx  = TW'(32'(wr_word) - CoefBase);
        rd_idx  = TW'(32'(rd_word) - CoefBase);
    end

    always_comb begin
        for (int i = 0; i < int'(DW); i++) begin
            strb_mask[i] = s00_axi_wstrb[i/8];
        end
    end

    // Datapath: operands sign-extended to full product width before multiplying
    assign mul_x  = PW'(hist_q[tap_q]);
    assign mul_c  = PW'($signed(coef_q[tap_q]));
    assign prod   = mul_x * mul_c;
    assign acc_sh = RW'(acc_q >>> (COEF_W - 1));

`ifdef FIR_SATURATE_EN
    always_comb begin
        result     = acc_sh[SAMPLE_W-1:0];
        result_ovf = 1'b0;
        if (acc_sh > SatMax) begin
            result     = SatMax[SAMPLE_W-1:0];
            result_ovf = 1'b1;
        end else if (acc_sh < SatMin) begin
            result     = SatMin[SAMPLE_W-1:0];
            result_ovf = 1'b1;
        end
    end
`else
    assign result     = acc_sh[SAMPLE_W-1:0];
    assign result_ovf = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        hist_d      = hist_q;
        coef_d      = coef_q;
        enable_d    = enable_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        drop_d      = drop_q;
        clr_hist    = 1'b0;
        din_wr      = 1'b0;

        if (wr_fire) begin
            if (wr_word == WordCtrl && s00_axi_wstrb[0]) begin
                enable_d = s00_axi_wdata[0];
                clr_hist = s00_axi_wdata[1];
            end
            if (wr_word == WordStatus && s00_axi_wstrb[0]) begin
                if (s00_axi_wdata[2]) overflow_d = 1'b0;
                if (s00_axi_wdata[3]) drop_d = 1'b0;
            end
            if (wr_word == WordDin) din_wr = 1'b1;
            if (wr_coef) begin
                coef_d[wr_idx] = (coef_q[wr_idx] & ~strb_mask[COEF_W-1:0]) |
                                 (s00_axi_wdata[COEF_W-1:0] & strb_mask[COEF_W-1:0]);
            end
        end

        if (rvalid_q && s00_axi_rready && rd_dout_q) out_valid_d = 1'b0;

        // Flag sets are evaluated after W1C so a same-cycle set wins
        if (clr_hist) begin
            for (int i = 0; i < int'(NUM_TAPS); i++) hist_d[i] = '0;
            acc_d   = '0;
            tap_d   = '0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (din_wr && enable_q) begin
                        for (int i = int'(NUM_TAPS) - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
                        hist_d[0] = s00_axi_wdata[SAMPLE_W-1:0];
                        acc_d     = '0;
                        tap_d     = '0;
                        state_d   = StMac;
                    end
                end
                StMac: begin
                    acc_d = acc_q + ACC_W'(prod);
                    if (tap_q == TW'(NUM_TAPS - 1)) state_d = StDone;
                    else tap_d = tap_q + 1'b1;
                end
                StDone: begin
                    dout_d      = result;
                    out_valid_d = 1'b1;
                    if (result_ovf) overflow_d = 1'b1;
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
            if (din_wr && enable_q && busy) drop_d = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_word)
            WordCtrl:   rd_data = DW'(enable_q);
            WordStatus: rd_data = DW'({drop_q, overflow_q, out_valid_q, busy});
            WordDout:   rd_data = DW'(dout_q);
            default:    if (rd_coef) rd_data = DW'(coef_q[rd_idx]);
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_dout_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
            if (wr_fire) bvalid_q <= 1'b1;
            else if (s00_axi_bready) bvalid_q <= 1'b0;
            arready_q <= s00_axi_arvalid & ~rvalid_q & ~arready_q;
            if (rd_fire) begin
                rvalid_q  <= 1'b1;
                rdata_q   <= rd_data;
                rd_dout_q <= (rd_word == WordDout);
            end else if (s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q     <= StIdle;
            tap_q       <= '0;
            acc_q       <= '0;
            enable_q    <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= 1'b0;
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            enable_q    <= enable_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            for (int i = 0; i < int'(NUM_TAPS); i++) begin
                hist_q[i] <= hist_d[i];
                coef_q[i] <= coef_d[i];
            end
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign irq             = out_valid_q;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0], s00_axi_wdata, strb_mask, acc_sh};

endmodule

// File: tb/tb_fir_axil_param.sv
// Self-checking bench for fir_axil_param: register table, directed corner sequences and
// randomized samples against a plain-arithmetic FIR reference model.
module tb_fir_axil_param;

    localparam int NT = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic [31:0] rd_v;

    shortint m_hist [NT];
    shortint m_coef [NT];
    bit      m_ovf;

    fir_axil_param dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got timeout, expected DUT response within bound", name);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 50) begin @(posedge clk); #1; n++; end
        if (!(awready && wready)) begin
            timeout("aw_accept");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        accept_cyc = cyc;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (bvalid) timeout("b_complete");
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        if (!arready) begin
            timeout("ar_accept");
            arvalid = 1'b0;
            d = 'x;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!rvalid) timeout("r_valid");
        d = rdata;
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(a, d);
        check(name, d, exp);
    endtask

    // Waits for irq; optionally checks it rose exactly NT+1 edges after the DIN accept edge
    task automatic wait_irq(input bit chk_lat);
        int n = 0;
        while (!irq && n < 100) begin @(posedge clk); #1; n++; end
        if (!irq) timeout("irq_rise");
        else if (chk_lat) check("latency", cyc - accept_cyc, NT + 1);
    endtask

    task automatic m_push(input shortint s);
        for (int k = NT - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = s;
    endtask

    function automatic logic [31:0] model_out(output bit ovf);
        longint acc = 0;
        for (int k = 0; k < NT; k++) acc += longint'(m_hist[k]) * longint'(m_coef[k]);
        acc = acc >>> 15;
        ovf = 1'b0;
`ifdef FIR_SATURATE_EN
        if (acc > 32767) begin acc = 32767; ovf = 1'b1; end
        else if (acc < -32768) begin acc = -32768; ovf = 1'b1; end
`else
        acc = longint'(shortint'(acc));
`endif
        return acc[31:0];
    endfunction

    typedef struct {
        bit          do_wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [16];

    initial begin
        bit ovf;
        int bp_bad;
        logic [31:0] exp_v, samp;

        vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h0,    "ctrl_rst"};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h0,    "status_rst"};
        vecs[2]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h0,    "dout_rst"};
        vecs[3]  = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h0,    "coef0_rst"};
        vecs[4]  = '{1'b1, 8'h40, 32'h00004000, 4'hF, 32'h4000, "coef0_wr"};
        vecs[5]  = '{1'b1, 8'h44, 32'h00001234, 4'h1, 32'h0034, "coef1_strb0"};
        vecs[6]  = '{1'b1, 8'h44, 32'h0000AB99, 4'h2, 32'hAB34, "coef1_strb1"};
        vecs[7]  = '{1'b1, 8'h44, 32'hFFFF0000, 4'hC, 32'hAB34, "coef1_strb_hi"};
        vecs[8]  = '{1'b1, 8'h00, 32'h00000003, 4'hF, 32'h1,    "ctrl_en_clr"};
        vecs[9]  = '{1'b1, 8'h00, 32'h00000000, 4'h2, 32'h1,    "ctrl_strb_masked"};
        vecs[10] = '{1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 32'h0,    "unmapped"};
        vecs[11] = '{1'b1, 8'h0C, 32'h00001234, 4'hF, 32'h0,    "dout_ro"};
        vecs[12] = '{1'b0, 8'h80, 32'h0,        4'h0, 32'h0,    "past_coef"};
        vecs[13] = '{1'b1, 8'h7C, 32'h0000FFFF, 4'h3, 32'hFFFF, "coef15"};
        vecs[14] = '{1'b1, 8'h80, 32'h00005555, 4'hF, 32'h0,    "past_coef_wr"};
        vecs[15] = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h4000, "coef0_no_alias"};

        // Reset with all valids asserted: every output must read 0
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {awready, wready, bvalid, arready, rvalid, bresp, rresp, irq},
              32'h0);
        check("reset_rdata", rdata, 32'h0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].do_wr) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            rd_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end

        // Impulse response
        do_reset();
        axi_write(8'h40, 32'h4000, 4'hF);
        axi_write(8'h44, 32'h2000, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        axi_write(8'h08, 32'h1000, 4'hF);
        wait_irq(1'b1);
        rd_chk("imp_status", 8'h04, 32'h2);
        rd_chk("imp_dout0", 8'h0C, 32'h0800);
        check("irq_cleared", {31'b0, irq}, 32'h0);
        axi_write(8'h08, 32'h0, 4'hF);
        wait_irq(1'b1);
        rd_chk("imp_dout1", 8'h0C, 32'h0400);

        // Overflow handling
        do_reset();
        axi_write(8'h40, 32'h7FFF, 4'hF);
        axi_write(8'h44, 32'h7FFF, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        axi_write(8'h08, 32'h7FFF, 4'hF);
        wait_irq(1'b0);
        rd_chk("ovf_dout0", 8'h0C, 32'h7FFE);
        axi_write(8'h08, 32'h7FFF, 4'hF);
        wait_irq(1'b0);
`ifdef FIR_SATURATE_EN
        rd_chk("ovf_dout1", 8'h0C, 32'h00007FFF);
        rd_chk("ovf_status", 8'h04, 32'h4);
`else
        rd_chk("ovf_dout1", 8'h0C, 32'hFFFFFFFC);
        rd_chk("ovf_status", 8'h04, 32'h0);
`endif
        axi_write(8'h04, 32'h4, 4'hF);
        rd_chk("ovf_w1c", 8'h04, 32'h0);

        // DIN while busy is dropped and leaves the history alone
        do_reset();
        axi_write(8'h40, 32'h4000, 4'hF);
        axi_write(8'h44, 32'h2000, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        axi_write(8'h08, 32'h1000, 4'hF);
        axi_write(8'h08, 32'h2000, 4'hF);
        wait_irq(1'b0);
        rd_chk("drop_status", 8'h04, 32'hA);
        rd_chk("drop_dout", 8'h0C, 32'h0800);
        rd_chk("drop_status2", 8'h04, 32'h8);
        axi_write(8'h04, 32'h8, 4'hF);
        rd_chk("drop_w1c", 8'h04, 32'h0);
        axi_write(8'h08, 32'h0, 4'hF);
        wait_irq(1'b0);
        rd_chk("drop_hist", 8'h0C, 32'h0400);

        // Write response backpressure with a concurrent read
        do_reset();
        bready = 1'b0;
        begin
            int n = 0;
            awaddr = 8'h40; wdata = 32'h1357; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
            while (!awready && n < 50) begin @(posedge clk); #1; n++; end
            if (!awready) timeout("bp_accept");
        end
        @(posedge clk); #1;
        check("bp_bvalid", {31'b0, bvalid}, 32'h1);
        check("bp_resp", {28'b0, bresp, rresp}, 32'h0);
        awaddr = 8'h48; wdata = 32'h2222;
        bp_bad = 0;
        fork
            begin
                repeat (10) begin
                    @(posedge clk); #1;
                    if (!bvalid || awready) bp_bad++;
                end
            end
            begin
                axi_read(8'h40, rd_v);
            end
        join
        check("bp_hold", bp_bad, 0);
        check("bp_read", rd_v, 32'h1357);
        bready = 1'b1;
        axi_write(8'h48, 32'h2222, 4'hF);
        rd_chk("bp_second", 8'h48, 32'h2222);

        // Reset in the middle of a MAC run
        do_reset();
        axi_write(8'h40, 32'h4000, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        axi_write(8'h08, 32'h1000, 4'hF);
        while (cyc < accept_cyc + 4) begin @(posedge clk); #1; end
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("rst_mac_irq", {31'b0, irq}, 32'h0);
        rd_chk("rst_mac_status", 8'h04, 32'h0);
        rd_chk("rst_mac_ctrl", 8'h00, 32'h0);
        rd_chk("rst_mac_coef0", 8'h40, 32'h0);
        rd_chk("rst_mac_dout", 8'h0C, 32'h0);
        repeat (20) @(posedge clk);
        #1 check("rst_mac_no_irq", {31'b0, irq}, 32'h0);

        // Clear history aborts a run and zeroes the taps
        do_reset();
        axi_write(8'h40, 32'h4000, 4'hF);
        axi_write(8'h44, 32'h2000, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF);
        axi_write(8'h08, 32'h3000, 4'hF);
        axi_write(8'h00, 32'h3, 4'hF);
        rd_chk("clr_status", 8'h04, 32'h0);
        repeat (20) @(posedge clk);
        #1 check("clr_no_irq", {31'b0, irq}, 32'h0);
        axi_write(8'h08, 32'h1000, 4'hF);
        wait_irq(1'b1);
        rd_chk("clr_dout", 8'h0C, 32'h0800);

        // Randomized samples against the reference model
        do_reset();
        m_ovf = 1'b0;
        for (int k = 0; k < NT; k++) begin
            m_hist[k] = 0;
            m_coef[k] = shortint'($urandom_range(0, 65535));
            axi_write(8'(8'h40 + 4 * k), {16'h0, m_coef[k]}, 4'hF);
        end
        axi_write(8'h00, 32'h1, 4'hF);
        for (int i = 0; i < 12; i++) begin
            samp = $urandom;
            m_push(shortint'(samp[15:0]));
            axi_write(8'h08, samp, 4'hF);
            wait_irq(1'b1);
            exp_v = model_out(ovf);
            if (ovf) m_ovf = 1'b1;
            rd_chk("rand_dout", 8'h0C, exp_v);
            rd_chk("rand_status", 8'h04, {29'b0, m_ovf, 2'b00});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
